// File: rtl/csr_timer_bank_if.sv
// csr_timer_bank_if: CSR read/write bus shared between the CSR file and the timer bank.
interface csr_timer_bank_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    modport master (output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, input csr_rvalue);
    modport slave  (input csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, output csr_rvalue);
endinterface

// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS down-count CSR timers, TID and a 64-bit stable counter.
// Define TIMER_PRESCALE_EN to add the TPRE tick divisor at CSR_BASE+3.
module csr_timer_bank #(
    parameter int          NUM_TIMERS = 4,
    parameter int          CNT_W      = 32,
    parameter logic [13:0] CSR_BASE   = 14'h40
) (
    input  logic                  clk,
    input  logic                  reset,
    csr_timer_bank_if.slave       bus,
    input  logic [31:0]           coreid_in,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic                  timer_int_any,
    output logic [63:0]           stable_cnt
);
    localparam logic [CNT_W-1:0] ONES = '1;
    logic [31:0] tid, tpre_rd, rv;
    logic [CNT_W-1:0] cfg [NUM_TIMERS];
    logic [CNT_W-1:0] cnt [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pend;
    logic [CNT_W-1:0] wm, wv;
    logic tick;
    assign wm = bus.csr_wmask[CNT_W-1:0];
    assign wv = bus.csr_wvalue[CNT_W-1:0];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tid        <= coreid_in;
            stable_cnt <= '0;
        end else begin
            if (bus.csr_we && bus.csr_num == CSR_BASE)
                tid <= bus.csr_wmask & bus.csr_wvalue | ~bus.csr_wmask & tid;
            stable_cnt <= stable_cnt + 64'd1;
        end
`ifdef TIMER_PRESCALE_EN
    logic [7:0] tpre, pre_cnt;
    logic tpre_wr;
    assign tpre_wr = bus.csr_we && bus.csr_num == CSR_BASE + 14'd3;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tpre    <= '0;
            pre_cnt <= '0;
        end else begin
            tpre    <= tpre_wr ? (bus.csr_wmask[7:0] & bus.csr_wvalue[7:0] | ~bus.csr_wmask[7:0] & tpre) : tpre;
            pre_cnt <= (tpre_wr || pre_cnt == tpre) ? 8'd0 : pre_cnt + 8'd1;
        end
    assign tick    = pre_cnt == tpre;
    assign tpre_rd = {24'd0, tpre};
`else
    assign tick    = 1'b1;
    assign tpre_rd = '0;
`endif
    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        localparam logic [13:0] BASE = CSR_BASE + 14'(4 * i);
        logic cfg_wr, load, clr, en, pend_q;
        logic [CNT_W-1:0] nv, cfg_q, cnt_q;
        assign cfg_wr = bus.csr_we && bus.csr_num == BASE + 14'd1;
        assign clr    = bus.csr_we && bus.csr_num == BASE + 14'd4 && bus.csr_wmask[0] && bus.csr_wvalue[0];
        assign nv     = cfg_wr ? (wm & wv | ~wm & cfg_q) : cfg_q;
        // Only a write that sets EN reloads; other TCFG writes let the count run on.
        assign load   = cfg_wr && wm[0] && wv[0];
        assign en     = nv[0] && tick;
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                cfg_q  <= '0;
                cnt_q  <= ONES;
                pend_q <= 1'b0;
            end else begin
                cfg_q <= nv;
                if (load)
                    cnt_q <= {nv[CNT_W-1:2], 2'b00};
                else if (en && cnt_q != ONES)
                    cnt_q <= (cnt_q == '0 && nv[1]) ? {nv[CNT_W-1:2], 2'b00} : cnt_q - CNT_W'(1);
                pend_q <= (en && cnt_q == '0) || (pend_q && !clr);
            end
        assign cfg[i]  = cfg_q;
        assign cnt[i]  = cnt_q;
        assign pend[i] = pend_q;
    end
    always_comb begin
        rv = (bus.csr_num == CSR_BASE) ? tid : '0;
        rv = rv | ((bus.csr_num == CSR_BASE + 14'd3) ? tpre_rd : '0);
        for (int j = 0; j < NUM_TIMERS; j++) begin
            rv = rv | ((bus.csr_num == CSR_BASE + 14'(4 * j + 1)) ? 32'(cfg[j]) : '0);
            rv = rv | ((bus.csr_num == CSR_BASE + 14'(4 * j + 2)) ? 32'(cnt[j]) : '0);
        end
        bus.csr_rvalue = bus.csr_re ? rv : '0;
    end
    assign timer_int     = pend;
    assign timer_int_any = |pend;
endmodule

// File: tb/tb_csr_timer_bank.sv
// tb_csr_timer_bank: directed CSR stimulus checked every cycle against a timer model
// that derives each count from its load cycle, plus hand-computed literal checks.
module tb_csr_timer_bank;
    localparam int          N    = 4;
    localparam logic [13:0] B    = 14'h40;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam longint      ALL1 = 64'hFFFF_FFFF;
    logic clk = 0, reset = 1, run = 0;
    logic [31:0] coreid = 32'h3;
    logic [N-1:0] timer_int;
    logic timer_int_any;
    logic [63:0] stable_cnt;
    int total = 0, bad = 0;

    csr_timer_bank_if bus();
    csr_timer_bank #(.NUM_TIMERS(N), .CNT_W(32), .CSR_BASE(B)) dut (
        .clk(clk), .reset(reset), .bus(bus), .coreid_in(coreid),
        .timer_int(timer_int), .timer_int_any(timer_int_any), .stable_cnt(stable_cnt));

    always #5 clk = ~clk;

    longint cyc;
    logic [31:0] m_tid;
    logic [31:0] m_cfg [N];
    logic [N-1:0] m_pend;
    logic m_en [N];
    logic m_per [N];
    longint m_t0 [N], m_v0 [N], m_l [N], m_frz [N];

    // Count seen n cycles after the anchor: linear descent, then wrap (one-shot) or cycle of L+1 (periodic).
    function automatic longint cnt_at(int i, longint n);
        longint e;
        if (!m_en[i]) return m_frz[i];
        if (m_v0[i] == ALL1) return ALL1;
        e = n - m_t0[i];
        if (e <= m_v0[i]) return m_v0[i] - e;
        if (!m_per[i]) return ALL1;
        return m_l[i] - (e - m_v0[i] - 1) % (m_l[i] + 1);
    endfunction

    function automatic logic [31:0] m_read(logic re, logic [13:0] a);
        if (!re) return '0;
        if (a == B) return m_tid;
        for (int i = 0; i < N; i++) begin
            if (a == B + 14'(4 * i + 1)) return m_cfg[i];
            if (a == B + 14'(4 * i + 2)) return 32'(cnt_at(i, cyc));
        end
        return '0;
    endfunction

    task automatic step_model();
        logic [31:0] mk, vl, nc;
        longint c;
        logic wr, hit, clr;
        mk = bus.csr_wmask;
        vl = bus.csr_wvalue;
        if (bus.csr_we && bus.csr_num == B) m_tid = mk & vl | ~mk & m_tid;
        for (int i = 0; i < N; i++) begin
            c   = cnt_at(i, cyc);
            wr  = bus.csr_we && bus.csr_num == B + 14'(4 * i + 1);
            nc  = wr ? (mk & vl | ~mk & m_cfg[i]) : m_cfg[i];
            hit = nc[0] && c == 0;
            clr = bus.csr_we && bus.csr_num == B + 14'(4 * i + 4) && mk[0] && vl[0];
            m_pend[i] = hit || (m_pend[i] && !clr);
            if (wr && mk[0] && vl[0]) begin
                m_en[i] = 1; m_t0[i] = cyc + 1; m_v0[i] = longint'(nc[31:2]) * 4;
                m_l[i] = m_v0[i]; m_per[i] = nc[1];
            end else if (wr && nc[0]) begin
                m_t0[i] = cyc; m_v0[i] = c; m_l[i] = longint'(nc[31:2]) * 4; m_per[i] = nc[1];
            end else if (!nc[0] && m_en[i]) begin
                m_en[i] = 0; m_frz[i] = c;
            end
            m_cfg[i] = nc;
        end
        cyc++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_tid = coreid; m_pend = '0;
            for (int i = 0; i < N; i++) begin
                m_cfg[i] = '0; m_en[i] = 0; m_per[i] = 0; m_frz[i] = ALL1;
                m_t0[i] = 0; m_v0[i] = 0; m_l[i] = 0;
            end
        end else step_model();
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("timer_int", 64'(timer_int), 64'(m_pend));
        chk("timer_int_any", 64'(timer_int_any), 64'(|m_pend));
        chk("stable_cnt", stable_cnt, 64'(cyc));
        chk("csr_rvalue", 64'(bus.csr_rvalue), 64'(m_read(bus.csr_re, bus.csr_num)));
    end

    task automatic step(int k = 1);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wr(logic [13:0] a, logic [31:0] m, logic [31:0] v);
        bus.csr_we = 1; bus.csr_num = a; bus.csr_wmask = m; bus.csr_wvalue = v;
        step();
        bus.csr_we = 0;
    endtask

    task automatic rd(logic [13:0] a, string nm, logic [31:0] exp);
        bus.csr_re = 1; bus.csr_num = a;
        #1;
        chk(nm, 64'(bus.csr_rvalue), 64'(exp));
    endtask

    initial begin
        bus.csr_re = 0; bus.csr_we = 0; bus.csr_num = '0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
        #1 reset = 0;
        step(2);
        run = 1;
        reset = 1;
        rd(B, "tid_reset", 32'h3);
        rd(B + 14'd2, "tval0_reset", ONES);
        chk("int_reset", 64'(timer_int), 64'h0);
        chk("stable_reset", stable_cnt, 64'h0);
        step(); chk("stable_1", stable_cnt, 64'd1);
        step(); chk("stable_2", stable_cnt, 64'd2);
        // one-shot channel 0
        wr(B + 14'd1, '1, 32'h11);
        for (int k = 16; k >= 0; k--) begin
            rd(B + 14'd2, "tval0_oneshot", 32'(k));
            chk("int0_low", 64'(timer_int[0]), 64'h0);
            step();
        end
        chk("int0_rise", 64'(timer_int[0]), 64'h1);
        rd(B + 14'd2, "tval0_halt", ONES);
        step(3);
        chk("int0_held", 64'(timer_int[0]), 64'h1);
        rd(B + 14'd2, "tval0_held", ONES);
        step();
        wr(B + 14'd4, 32'h1, 32'h1);
        chk("int0_clr", 64'(timer_int[0]), 64'h0);
        // periodic channel 1
        step();
        wr(B + 14'd5, '1, 32'h0B);
        for (int j = 0; j <= 8; j++) begin
            rd(B + 14'd6, "tval1_period", 32'(8 - j));
            step();
        end
        chk("int_period1", 64'(timer_int), 64'h2);
        rd(B + 14'd6, "tval1_reload", 32'd8);
        wr(B + 14'd8, 32'h1, 32'h0);
        chk("ticlr_zero_ignored", 64'(timer_int), 64'h2);
        wr(B + 14'd8, 32'h1, 32'h1);
        chk("int1_clr", 64'(timer_int), 64'h0);
        step(6);
        chk("int1_before_2nd", 64'(timer_int), 64'h0);
        rd(B + 14'd6, "tval1_zero", 32'd0);
        step();
        chk("int1_2nd", 64'(timer_int), 64'h2);
        // channel 3 stopped by EN=0 write holds its count
        wr(B + 14'd13, '1, 32'h29);
        step(5);
        wr(B + 14'd13, 32'h1, 32'h0);
        rd(B + 14'd14, "tval3_freeze", 32'd35);
        step(3);
        rd(B + 14'd14, "tval3_held", 32'd35);
        rd(B + 14'd13, "tcfg3_off", 32'h28);
        // channel 2: masked write, then clear colliding with set
        step();
        wr(B + 14'd9, '1, 32'h5);
        wr(B + 14'd9, 32'h2, 32'h0);
        rd(B + 14'd10, "tval2_no_reload", 32'd3);
        rd(B + 14'd9, "tcfg2_masked", 32'h5);
        step(3);
        rd(B + 14'd10, "tval2_zero", 32'd0);
        wr(B + 14'd12, 32'h1, 32'h1);
        chk("int2_set_wins", 64'(timer_int[2]), 64'h1);
        rd(B + 14'd10, "tval2_halt", ONES);
        // TID masking and read-during-write
        step();
        wr(B, 32'hFFFF_0000, 32'hABCD_1234);
        rd(B, "tid_masked", 32'hABCD_0003);
        step();
        bus.csr_re = 1; bus.csr_we = 1; bus.csr_num = B; bus.csr_wmask = '1; bus.csr_wvalue = 32'h1111_2222;
        #1 chk("rd_during_wr", 64'(bus.csr_rvalue), 64'hABCD_0003);
        step();
        bus.csr_we = 0;
        rd(B, "tid_after", 32'h1111_2222);
        step();
        rd(14'h100, "unmapped", 32'h0);
        rd(B + 14'd7, "reserved7", 32'h0);
        step();
        bus.csr_re = 0; bus.csr_num = B;
        #1 chk("re_low", 64'(bus.csr_rvalue), 64'h0);
`ifndef TIMER_PRESCALE_EN
        step();
        wr(B + 14'd3, '1, '1);
        rd(B + 14'd3, "base3_zero", 32'h0);
`endif
        // asynchronous reset mid-count
        step();
        wr(B + 14'd1, '1, 32'h11);
        step(3);
        chk("int_pre_reset", 64'(timer_int_any), 64'h1);
        coreid = 32'h7;
        #1 reset = 0;
        #1;
        chk("int_async_rst", 64'(timer_int), 64'h0);
        chk("stable_async_rst", stable_cnt, 64'h0);
        step();
        rd(B + 14'd1, "tcfg0_rst", 32'h0);
        rd(B + 14'd2, "tval0_rst", ONES);
        step();
        rd(B + 14'd6, "tval1_rst", ONES);
        rd(B, "tid_rst", 32'h7);
        step();
        reset = 1;
        step(2);
        chk("stable_after_rst", stable_cnt, 64'd2);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
